// File: rtl/hilo_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package cpu_defs;

   // HI/LO operation presented by the EXE stage
   typedef enum logic [3:0] {
      NONE  = 4'd0,
      MULT  = 4'd1,
      MULTU = 4'd2,
      DIV   = 4'd3,
      DIVU  = 4'd4,
      MFHI  = 4'd5,
      MFLO  = 4'd6,
      MTHI  = 4'd7,
      MTLO  = 4'd8
   } hilo_op_t;

   // Sequencer state
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL      = 2'd1,
      DIV_ITER = 2'd2,
      DIV_FIX  = 2'd3
   } hilo_state_t;

   localparam int unsigned MUL_LATENCY_DEFAULT = 2;
   localparam int unsigned DIV_ITERS_DEFAULT   = 32;

   // Operations that modify HI/LO and therefore must only be issued once
   function automatic logic is_write_op(input hilo_op_t op);
      case (op)
         MULT, MULTU, DIV, DIVU, MTHI, MTLO: is_write_op = 1'b1;
         default:                            is_write_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hilo_seq_div_iter.sv
// Unsigned radix-2 restoring divider: load on start, one quotient bit per step.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] r_r;
   logic [WIDTH-1:0] d_r;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Trial subtraction; MSB of trial set means the partial remainder is below the divisor
   always_comb begin
      shifted = {r_r, q_r[WIDTH-1]};
      trial   = shifted - {1'b0, d_r};
   end

   // Load operands on start, otherwise shift in one quotient bit per step
   always_ff @(posedge clk) begin
      if (reset) begin
         q_r <= '0;
         r_r <= '0;
         d_r <= '0;
      end else if (start) begin
         q_r <= dividend;
         r_r <= '0;
         d_r <= divisor;
      end else if (step) begin
         if (!trial[WIDTH]) begin
            r_r <= trial[WIDTH-1:0];
            q_r <= {q_r[WIDTH-2:0], 1'b1};
         end else begin
            r_r <= shifted[WIDTH-1:0];
            q_r <= {q_r[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign quotient  = q_r;
   assign remainder = r_r;

endmodule

// File: rtl/hilo_seq.sv
// HI/LO register owner: commits each EXE HI/LO op once, runs MULT/DIV in the background.
module hilo_seq
   import cpu_defs::*;
#(
   parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT,  // must be >= 2
   parameter int unsigned DIV_ITERS   = DIV_ITERS_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  hilo_op_t    hi_lo_op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        wr_disable,
   input  logic        req_advance,
   output logic        hi_lo_ready,
   output logic [31:0] hi_lo_result,
   output logic        busy
);

   localparam int unsigned CNT_W = 8;

   hilo_state_t        state;
   logic [31:0]        hi;
   logic [31:0]        lo;
   logic               issued;
   logic [CNT_W-1:0]   cnt;
   logic signed [63:0] mul_a;
   logic signed [63:0] mul_b;
   logic signed [63:0] prod;
   logic               div_neg_q;
   logic               div_neg_r;
   logic               div_zero;
   logic [31:0]        div_raw;

   logic               act;
   logic               fire;
   logic               is_mul;
   logic               is_div;
   logic               is_signed;
   logic [31:0]        mag1;
   logic [31:0]        mag2;
   logic [31:0]        quo;
   logic [31:0]        rem;
   logic [31:0]        quo_fix;
   logic [31:0]        rem_fix;

   // Handshake decode, operand magnitudes and read mux
   always_comb begin
      act         = req_valid & (hi_lo_op != NONE);
      busy        = (state != IDLE);
      hi_lo_ready = act & (issued | ~busy);
      fire        = act & hi_lo_ready & ~wr_disable & ~issued;
      is_mul      = (hi_lo_op == MULT) | (hi_lo_op == MULTU);
      is_div      = (hi_lo_op == DIV)  | (hi_lo_op == DIVU);
      is_signed   = (hi_lo_op == MULT) | (hi_lo_op == DIV);
      mag1        = (is_signed & src1[31]) ? -src1 : src1;
      mag2        = (is_signed & src2[31]) ? -src2 : src2;
      quo_fix     = div_neg_q ? -quo : quo;
      rem_fix     = div_neg_r ? -rem : rem;
      hi_lo_result = '0;
      if (hi_lo_ready && hi_lo_op == MFHI) hi_lo_result = hi;
      if (hi_lo_ready && hi_lo_op == MFLO) hi_lo_result = lo;
   end

   div_iter #(
      .WIDTH(32)
   ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (fire & is_div),
      .step     (state == DIV_ITER),
      .dividend (mag1),
      .divisor  (mag2),
      .quotient (quo),
      .remainder(rem)
   );

   // Issue tracking, sequencer FSM and HI/LO updates
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         hi        <= '0;
         lo        <= '0;
         issued    <= 1'b0;
         cnt       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         prod      <= '0;
         div_neg_q <= 1'b0;
         div_neg_r <= 1'b0;
         div_zero  <= 1'b0;
         div_raw   <= '0;
      end else begin
         // leaving the stage (or bubble) clears issued even in the fire cycle
         if (!req_valid || req_advance)
            issued <= 1'b0;
         else if (fire && is_write_op(hi_lo_op))
            issued <= 1'b1;

         case (state)
            IDLE: begin
               if (fire && is_mul) begin
                  state <= MUL;
                  cnt   <= '0;
                  mul_a <= is_signed ? {{32{src1[31]}}, src1} : {32'b0, src1};
                  mul_b <= is_signed ? {{32{src2[31]}}, src2} : {32'b0, src2};
               end else if (fire && is_div) begin
                  state     <= DIV_ITER;
                  cnt       <= '0;
                  div_neg_q <= is_signed & (src1[31] ^ src2[31]);
                  div_neg_r <= is_signed & src1[31];
                  div_zero  <= (src2 == '0);
                  div_raw   <= src1;
               end
               if (fire && hi_lo_op == MTHI) hi <= src1;
               if (fire && hi_lo_op == MTLO) lo <= src1;
            end
            MUL: begin
               // 33x33 signed product carried in 64-bit sign/zero-extended operands
               prod <= mul_a * mul_b;
               if (cnt == CNT_W'(MUL_LATENCY - 1)) begin
                  {hi, lo} <= prod;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DIV_ITER: begin
               if (cnt == CNT_W'(DIV_ITERS - 1))
                  state <= DIV_FIX;
               else
                  cnt <= cnt + 1'b1;
            end
            DIV_FIX: begin
               if (div_zero) begin
                  lo <= '1;
                  hi <= div_raw;
               end else begin
                  lo <= quo_fix;
                  hi <= rem_fix;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_seq.sv
// Self-checking bench for hilo_seq: expected HI/LO values are queued at issue
// and drained through MFLO/MFHI reads.
module tb_hilo_seq;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   hilo_op_t    hi_lo_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        wr_disable;
   logic        req_advance;
   logic        hi_lo_ready;
   logic [31:0] hi_lo_result;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   hilo_seq #(
      .MUL_LATENCY(2),
      .DIV_ITERS  (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .hi_lo_op    (hi_lo_op),
      .src1        (src1),
      .src2        (src2),
      .wr_disable  (wr_disable),
      .req_advance (req_advance),
      .hi_lo_ready (hi_lo_ready),
      .hi_lo_result(hi_lo_result),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Reference {HI,LO} for arithmetic ops
   function automatic logic [63:0] model(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      int          sa;
      int          sb;
      sa = a;
      sb = b;
      r  = '0;
      case (op)
         MULT:  r = longint'(sa) * longint'(sb);
         MULTU: r = {32'b0, a} * {32'b0, b};
         DIV: begin
            if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
            else r = {32'(sa % sb), 32'(sa / sb)};
         end
         DIVU: begin
            if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
            else r = {a % b, a / b};
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid   = 1'b0;
      hi_lo_op    = NONE;
      src1        = '0;
      src2        = '0;
      wr_disable  = 1'b0;
      req_advance = 1'b0;
   endtask

   // Present op with req_advance=1 until it is accepted; optionally queue its result
   task automatic issue(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input bit score, output int waited);
      logic [63:0] m;
      bit          ok;
      ok     = 1'b0;
      waited = 0;
      req_valid = 1'b1; hi_lo_op = op; src1 = a; src2 = b;
      wr_disable = 1'b0; req_advance = 1'b1;
      if (score) begin
         m = model(op, a, b);
         exp_q.push_back(m[31:0]);
         exp_q.push_back(m[63:32]);
      end
      for (int i = 0; i < 100 && !ok; i++) begin
         #2;
         if (hi_lo_ready === 1'b1) ok = 1'b1;
         else waited++;
         step();
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL issue_%s: ready never rose (busy=%b)", op.name(), busy);
      end
      idle_inputs();
   endtask

   // Scoreboard drain: read HI or LO and compare with the next queued value
   task automatic drain_mf(input hilo_op_t op, input string name);
      logic [31:0] expv;
      bit          got;
      got = 1'b0;
      req_valid = 1'b1; hi_lo_op = op; wr_disable = 1'b0; req_advance = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         #2;
         if (hi_lo_ready === 1'b1) begin
            got = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s: scoreboard empty, result=%h", name, hi_lo_result);
            end else begin
               expv = exp_q.pop_front();
               if (hi_lo_result !== expv) begin
                  errors++;
                  $display("FAIL %s: result=%h expected=%h", name, hi_lo_result, expv);
               end
            end
            req_advance = 1'b1;
         end
         step();
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s: ready timeout, busy=%b", name, busy);
      end
      idle_inputs();
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         #2;
         if (busy === 1'b0) done = 1'b1;
         else step();
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL %s: busy stuck at %b", name, busy);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      #2;
      checks++;
      if (hi_lo_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got=%b expected=0", hi_lo_ready); end
      checks++;
      if (hi_lo_result !== 32'h0) begin errors++; $display("FAIL reset_result: got=%h expected=0", hi_lo_result); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%b expected=0", busy); end
      step();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      drain_mf(MFLO, "reset_lo");
      drain_mf(MFHI, "reset_hi");
   endtask

   // Multiply issued at T, MFLO presented at T+1 must wait until T+3
   task automatic test_mult(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b, input string name);
      int w;
      issue(op, a, b, 1'b1, w);
      req_valid = 1'b1; hi_lo_op = MFLO; req_advance = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         #2;
         checks++;
         if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_T%0d: got=%b expected=1", name, c, busy); end
         checks++;
         if (hi_lo_ready !== 1'b0) begin errors++; $display("FAIL %s_ready_T%0d: got=%b expected=0", name, c, hi_lo_ready); end
         step();
      end
      #2;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_T3: got=%b expected=0", name, busy); end
      checks++;
      if (hi_lo_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_T3: got=%b expected=1", name, hi_lo_ready); end
      drain_mf(MFLO, {name, "_lo"});
      drain_mf(MFHI, {name, "_hi"});
   endtask

   task automatic test_div();
      int w;
      int n;
      bit fell;
      issue(DIV, 32'hFFFF_FFF9, 32'h2, 1'b1, w);
      n = 0;
      fell = 1'b0;
      for (int i = 0; i < 100 && !fell; i++) begin
         #2;
         if (busy !== 1'b1) fell = 1'b1;
         else begin n++; step(); end
      end
      checks++;
      if (n != 33) begin errors++; $display("FAIL div_busy_len: got=%0d expected=33", n); end
      drain_mf(MFLO, "div_m7_2_lo");
      drain_mf(MFHI, "div_m7_2_hi");

      issue(DIVU, 32'h7, 32'h0, 1'b1, w);
      wait_idle("divu_zero");
      drain_mf(MFLO, "divu_zero_lo");
      drain_mf(MFHI, "divu_zero_hi");

      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, w);
      wait_idle("div_ovf");
      drain_mf(MFLO, "div_ovf_lo");
      drain_mf(MFHI, "div_ovf_hi");
   endtask

   task automatic test_hold();
      logic [63:0] m;
      bit          exp_busy [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      req_valid = 1'b1; hi_lo_op = MULT; src1 = 32'd5; src2 = 32'hFFFF_FFFD;
      wr_disable = 1'b0; req_advance = 1'b0;
      m = model(MULT, 32'd5, 32'hFFFF_FFFD);
      exp_q.push_back(m[31:0]);
      exp_q.push_back(m[63:32]);
      for (int c = 0; c < 5; c++) begin
         #2;
         checks++;
         if (hi_lo_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_c%0d: got=%b expected=1", c, hi_lo_ready); end
         checks++;
         if (busy !== exp_busy[c]) begin errors++; $display("FAIL hold_busy_c%0d: got=%b expected=%b", c, busy, exp_busy[c]); end
         checks++;
         if (hi_lo_result !== 32'h0) begin errors++; $display("FAIL hold_result_c%0d: got=%h expected=0", c, hi_lo_result); end
         step();
      end
      idle_inputs();
      drain_mf(MFLO, "hold_lo");
      drain_mf(MFHI, "hold_hi");
   endtask

   task automatic test_mt();
      int w;
      issue(MTLO, 32'h0000_AAAA, 32'h0, 1'b0, w);
      req_valid = 1'b1; hi_lo_op = MTLO; src1 = 32'h1234; wr_disable = 1'b1; req_advance = 1'b1;
      #2;
      checks++;
      if (hi_lo_ready !== 1'b1) begin errors++; $display("FAIL mt_disabled_ready: got=%b expected=1", hi_lo_ready); end
      step();
      idle_inputs();
      exp_q.push_back(32'h0000_AAAA);
      drain_mf(MFLO, "mtlo_disabled");

      issue(MTLO, 32'h1234, 32'h0, 1'b0, w);
      #2;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mt_busy: got=%b expected=0", busy); end
      exp_q.push_back(32'h1234);
      drain_mf(MFLO, "mtlo_enabled");

      // held with wr_disable, fires once wr_disable drops
      req_valid = 1'b1; hi_lo_op = MTHI; src1 = 32'h55; wr_disable = 1'b1; req_advance = 1'b0;
      step(); step();
      wr_disable = 1'b0; req_advance = 1'b1;
      step();
      idle_inputs();
      exp_q.push_back(32'h55);
      drain_mf(MFHI, "mthi_late");
   endtask

   task automatic test_back_to_back();
      int w;
      issue(MULT, 32'd3, 32'd5, 1'b0, w);
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, w);
      checks++;
      if (w != 2) begin errors++; $display("FAIL b2b_wait: got=%0d cycles expected=2", w); end
      issue(DIVU, 32'd1000, 32'd7, 1'b1, w);
      checks++;
      if (w != 2) begin errors++; $display("FAIL b2b_div_wait: got=%0d cycles expected=2", w); end
      wait_idle("b2b_div");
      // the MULTU result was overwritten; discard its entries
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      drain_mf(MFLO, "b2b_lo");
      drain_mf(MFHI, "b2b_hi");
   endtask

   task automatic test_reset_mid_div();
      int w;
      issue(DIV, 32'd100, 32'd7, 1'b0, w);
      for (int c = 0; c < 10; c++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #2;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got=%b expected=0", busy); end
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      drain_mf(MFLO, "midreset_lo");
      drain_mf(MFHI, "midreset_hi");
      test_mult(MULTU, 32'd3, 32'd4, "post_reset_multu");
   endtask

   task automatic test_random();
      int          w;
      hilo_op_t    ops [4] = '{MULT, MULTU, DIV, DIVU};
      logic [31:0] a;
      logic [31:0] b;
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i == 3) ? 32'h0 : $urandom;
         issue(ops[i % 4], a, b, 1'b1, w);
         wait_idle("rand");
         drain_mf(MFLO, "rand_lo");
         drain_mf(MFHI, "rand_hi");
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_mult(MULT,  32'hFFFF_FFFF, 32'h2, "mult");
      test_mult(MULTU, 32'hFFFF_FFFF, 32'h2, "multu");
      test_div();
      test_hold();
      test_mt();
      test_back_to_back();
      test_reset_mid_div();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got=%0d entries expected=0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hilo_seq.md
# hilo_seq

Multiply/divide sequencer that owns the HI/LO register pair and schedules multi-cycle MULT/DIV work for the EXE stage. The EXE stage presents its hi_lo operation together with rs/rt values. The block commits each operation exactly once and runs multiplies (fixed 2-cycle latency) and divides (33 cycles) in the background. It stalls only a later HI/LO access that arrives while a computation is in flight.

## Interface
Parameters:
- MUL_LATENCY, 2: cycles busy after a MULT/MULTU fire
- DIV_ITERS, 32: restoring-division iterations; one fix-up cycle follows them

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EXE holds a valid instruction
- hi_lo_op  in  hilo_op_t (4)  NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
- src1  in  32  rs value
- src2  in  32  rt value
- wr_disable  in  1  instruction squashed or excepting; must not modify HI/LO
- req_advance  in  1  the current EXE instruction leaves the stage this cycle
- hi_lo_ready  out  1  operation may complete; drives EXE ready_go
- hi_lo_result  out  32  HI (MFHI) or LO (MFLO), else 0
- busy  out  1  MULT/DIV in flight

## Operation
- Definitions:
  - act = req_valid & (hi_lo_op != NONE)
  - fire = act & hi_lo_ready & ~wr_disable & ~issued
- hi_lo_ready = act & (issued | ~busy), combinational.
- issued flag:
  - set on fire of any write-type op (MULT/MULTU/DIV/DIVU/MTHI/MTLO);
  - cleared when req_advance=1 or req_valid=0, with clear winning over set;
  - prevents re-issue while an instruction is held in EXE by back-pressure.
- MTHI/MTLO: HI or LO takes src1 at the fire edge; busy is unaffected.
- MFHI/MFLO: hi_lo_result = current HI/LO while ready; no state change; wr_disable is ignored.
- FSM states and transitions:
  - IDLE -> MUL on fire of MULT/MULTU.
  - MUL counts MUL_LATENCY cycles; 64-bit product written {HI,LO} on the last cycle; -> IDLE.
  - IDLE -> DIV_ITER on fire of DIV/DIVU. Operand magnitudes and signs are latched; counter = 0.
  - DIV_ITER: one restoring step per cycle, DIV_ITERS cycles; -> DIV_FIX.
  - DIV_FIX: apply signs; write LO = quotient, HI = remainder; -> IDLE.
- Signed results: quotient is negative iff the signs differ; remainder takes the dividend's sign.
- Divide by zero: LO=32'hFFFF_FFFF, HI=src1 (raw); no sign fix.
- 0x8000_0000 / -1 (signed): LO=0x8000_0000, HI=0. No trap.
- busy = (state != IDLE).
- A fired operation is never aborted; a later wr_disable or flush does not cancel it.
- Reset mid-operation: state=IDLE, HI=LO=0, issued=0, divider/counter cleared.

## Timing
- Reset values:
  - hi_lo_ready=0 and hi_lo_result=0 (req_valid=0 after reset);
  - busy=0, HI=0, LO=0.
- MULT fired in cycle T:
  - busy=1 in T+1..T+2;
  - HI/LO new value visible and busy=0 in T+3;
  - hi_lo_ready stays 1 through T..T+2 while issued holds.
- DIV fired in T:
  - busy=1 in T+1..T+33 (32 iterations + fix);
  - result visible in T+34.
- MF/MT/MULT/DIV presented while busy: ready=0 until the cycle busy falls, then ready=1 in that same cycle. A MFLO sees the new LO in that cycle; no bypass of in-flight results.
- A new MULT/DIV may fire in the first cycle with busy=0 (back-to-back).
- wr_disable=1 in the would-be fire cycle:
  - no state change;
  - ready still reflects busy;
  - the op may fire later if wr_disable drops while the instruction is still held.

## Structure
- cpu_defs package:
  - hilo_op_t enum (4-bit);
  - hilo_state_t {IDLE, MUL, DIV_ITER, DIV_FIX};
  - MUL_LATENCY and DIV_ITERS defaults.
- Sub-module div_iter: unsigned radix-2 restoring core.
  - Operands are loaded on a start pulse, one step per cycle.
  - It exposes quotient/remainder.
  - Sign handling stays in hilo_seq.
- The multiplier is an inferred signed 33x33 product registered over MUL_LATENCY stages.

## Test plan
- MULT src1=0xFFFF_FFFF src2=2 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFFE; MFLO issued at T+1 gets ready at T+3; MULTU with the same operands -> HI=1, LO=0xFFFF_FFFE.
- DIV -7/2 -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF at T+34; busy high for exactly 33 cycles.
- DIVU 7/0 -> LO=0xFFFF_FFFF, HI=7; DIV 0x8000_0000/0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- MULT held in EXE 5 cycles (req_advance=0): exactly one computation; hi_lo_ready=1 throughout; HI/LO written once.
- MTLO 0x1234 with wr_disable=1 -> LO unchanged; same op with wr_disable=0 -> MFLO returns 0x1234 next cycle.
- Reset at DIV iteration 10 -> busy=0, HI=LO=0 next cycle; following MULTU 3x4 -> LO=12 at T+3.
